// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared custom ALU: grant, issue,
// bounded wait for completion, then return the result over valid/ready.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | arbitrate; reqN_ready asserted for the winner, capture op
// S_ISSUE | one-cycle alu_start pulse, clear wait counter
// S_WAIT  | wait for alu_done, give up after TIMEOUT cycles
// S_RESP  | present rsp_data/rsp_err to the granted requester
module alu_req_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic any_valid;
  logic gnt_sel;
  logic rsp_accept;
  logic alu_drive;

  // Winner in IDLE: the sole requester, or on a tie the one not served last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = req1_valid;
    end
    req0_ready = (state_q == S_IDLE) & any_valid & ~gnt_sel;
    req1_ready = (state_q == S_IDLE) & any_valid & gnt_sel;
    rsp_accept = grant_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d = gnt_sel;
          op_d    = gnt_sel ? req1_op : req0_op;
          a_d     = gnt_sel ? req1_a  : req0_a;
          b_d     = gnt_sel ? req1_b  : req0_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the final wait cycle still counts as success.
        if (alu_done) begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_accept) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ALU operands are only presented while an operation is in flight.
  always_comb begin
    alu_drive  = (state_q == S_ISSUE) | (state_q == S_WAIT);
    alu_start  = (state_q == S_ISSUE);
    alu_op     = alu_drive ? op_q : '0;
    alu_a      = alu_drive ? a_q  : '0;
    alu_b      = alu_drive ? b_q  : '0;
    rsp0_valid = (state_q == S_RESP) & ~grant_q;
    rsp1_valid = (state_q == S_RESP) & grant_q;
    rsp_data   = rsp_data_q;
    rsp_err    = rsp_err_q;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares a single custom-ALU execution unit between two requesters.
- Round-robin arbitration grants one requester at a time; the granted operation is issued to the ALU with a start pulse.
- The controller then waits for ALU completion, bounded by a timeout, and returns the result to the granted requester over a valid/ready handshake.
- Sits between the top-level IO decode logic (requesters) and the ALU core.

Parameters:
- DATA_W, 8, operand and result width.
- OP_W, 4, ALU opcode width.
- TIMEOUT, 15, maximum number of WAIT cycles before reporting an error. Must be >= 1. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OP_W  requester 0 opcode.
- req0_a  input  DATA_W  requester 0 operand A.
- req0_b  input  DATA_W  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp0_valid  output  1  response available for requester 0.
- rsp0_ready  input  1  requester 0 accepts the response.
- rsp1_valid  output  1  response available for requester 1.
- rsp1_ready  input  1  requester 1 accepts the response.
- rsp_data  output  DATA_W  shared response data.
- rsp_err  output  1  shared response flag; 1 = ALU timeout.
- alu_start  output  1  one-cycle issue pulse to the ALU.
- alu_op  output  OP_W  opcode to the ALU.
- alu_a  output  DATA_W  operand A to the ALU.
- alu_b  output  DATA_W  operand B to the ALU.
- alu_done  input  1  ALU result valid (pulse or level; sampled only in WAIT).
- alu_result  input  DATA_W  ALU result, valid when alu_done = 1.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE.
  - All outputs 0: alu_op/a/b, rsp_data, rsp_err, and all valid/ready/start signals.
  - Timeout counter = 0; last_grant = 1, so requester 0 wins the first tie.
- Reset mid-operation abandons the in-flight operation without emitting a response. A later alu_done is ignored, because alu_done is ignored outside WAIT.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester not equal to last_grant.
  - reqN_ready is combinational: (state == IDLE) & grant == N. It is high for exactly one cycle per accepted operation, and never for both requesters in the same cycle.
  - On the handshake: capture op/a/b into registers, record the granted index, go to ISSUE.
  - If no request is valid, stay in IDLE.
  - A requester may drop valid before it is granted; it simply gets no grant.
- ISSUE:
  - alu_start = 1 for this cycle only.
  - alu_op/a/b are driven from the captured registers and held stable from ISSUE through the last WAIT cycle.
  - Counter cleared to 0. Next state is WAIT.
  - alu_done in the ISSUE cycle is ignored.
- WAIT:
  - alu_done = 1: capture alu_result into rsp_data, set rsp_err = 0, go to RESP.
  - Else, if counter == TIMEOUT-1: set rsp_data = 0, rsp_err = 1, go to RESP.
  - Else: counter increments by 1.
  - WAIT therefore lasts at most TIMEOUT cycles.
  - If alu_done and the timeout coincide, alu_done wins.
- RESP:
  - rspN_valid = 1 for the granted requester only.
  - rsp_data and rsp_err are held stable until rspN_ready = 1.
  - On the handshake: last_grant = granted index, go to IDLE.
  - rspN_ready on the non-granted requester is ignored.
- Timing, with the request handshake in cycle T:
  - alu_start in T+1.
  - Earliest alu_done sample in T+2.
  - rsp_valid earliest in T+3.
  - Next grant earliest in the cycle after the response handshake.
  - Minimum 4 cycles per operation.
- No combinational path from alu_result to rsp_data; the result is registered.

Test Plan:
1. Single request: req0 op=0x1, a=0x12, b=0x34; ALU model asserts done 2 cycles after start with result 0x46 -> req0_ready high for 1 cycle; alu_start pulses once with a=0x12, b=0x34; rsp0_valid with rsp_data=0x46, rsp_err=0; rsp1_valid stays 0.
2. Contention: both requests held valid continuously, rsp ready tied high, ALU done 1 cycle after start -> grant order 0,1,0,1; 4 cycles per operation; never both ready asserted.
3. Timeout: ALU never asserts done, TIMEOUT=15 -> rsp valid appears 16 cycles after the alu_start cycle with rsp_data=0x00, rsp_err=1; the next request is served normally.
4. Boundary: alu_done on the 15th WAIT cycle -> rsp_err=0 with the result captured; alu_done asserted in the ISSUE cycle only -> ignored.
5. Backpressure: rsp0_ready low for 5 cycles while req1 is valid -> rsp0_valid, rsp_data and rsp_err held stable; req1_ready stays 0 until the cycle after the rsp0 handshake.
6. Reset in WAIT: assert rst for 1 cycle, then pulse alu_done -> no rsp valid; all outputs 0; busy=0; a following req1 request completes correctly.
